// File: rtl/trig_counter_bank_if.sv
// Host-side bundle for trig_counter_bank: trigger pulses, mode/flag controls,
// snapshot strobe, readout select and all status/readout returns.
interface trig_counter_bank_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 32
);
   logic [N_CH-1:0]  trig_reset;
   logic [N_CH-1:0]  trig_load;
   logic [N_CH-1:0]  trig_up;
   logic [N_CH-1:0]  trig_down;
   logic [CNT_W-1:0] load_value;
   logic [N_CH-1:0]  sat_mode;
   logic [N_CH-1:0]  flag_clr;
   logic             snap;
   logic [3:0]       rd_sel;
   logic [1:0]       rd_word;
   logic [15:0]      rd_data;
   logic [15:0]      snap_cnt;
   logic [N_CH-1:0]  ovf_flag;
   logic [N_CH-1:0]  unf_flag;
   logic [N_CH-1:0]  tc_pulse;

   modport master (
      output trig_reset, trig_load, trig_up, trig_down, load_value,
             sat_mode, flag_clr, snap, rd_sel, rd_word,
      input  rd_data, snap_cnt, ovf_flag, unf_flag, tc_pulse
   );

   modport slave (
      input  trig_reset, trig_load, trig_up, trig_down, load_value,
             sat_mode, flag_clr, snap, rd_sel, rd_word,
      output rd_data, snap_cnt, ovf_flag, unf_flag, tc_pulse
   );
endinterface

// File: rtl/trig_counter_bank.sv
// Bank of N_CH up/down event counters with wrap/saturate modes, sticky
// overflow/underflow flags, a coherent snapshot into shadow registers and a
// registered 16-bit readout mux over the shadows.
module trig_counter_bank #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 32
) (
   input  logic                  sys_clk,
   input  logic                  reset,
   trig_counter_bank_if.slave    bus
);
   localparam int NW = CNT_W / 16;
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q    [N_CH];
   logic [CNT_W-1:0] cnt_d    [N_CH];
   logic [CNT_W-1:0] shadow_q [N_CH];
   logic [CNT_W-1:0] shadow_d [N_CH];
   logic [N_CH-1:0]  ovf_q, ovf_d;
   logic [N_CH-1:0]  unf_q, unf_d;
   logic [N_CH-1:0]  tc_q, tc_d;
   logic [N_CH-1:0]  ev_ovf_s, ev_unf_s;
   logic [15:0]      rd_data_q, rd_data_d;
   logic [15:0]      snap_cnt_q, snap_cnt_d;

   // Next counter value per channel with trigger priority, plus terminal-count events.
   always_comb begin
      ev_ovf_s = {N_CH{1'b0}};
      ev_unf_s = {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (bus.trig_reset[i]) begin
            cnt_d[i] = CNT_ZERO;
         end else if (bus.trig_load[i]) begin
            cnt_d[i] = bus.load_value;
         end else if (bus.trig_up[i] && bus.trig_down[i]) begin
            cnt_d[i] = cnt_q[i];
         end else if (bus.trig_up[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               ev_ovf_s[i] = 1'b1;
               cnt_d[i]    = bus.sat_mode[i] ? CNT_MAX : CNT_ZERO;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end else if (bus.trig_down[i]) begin
            if (cnt_q[i] == CNT_ZERO) begin
               ev_unf_s[i] = 1'b1;
               cnt_d[i]    = bus.sat_mode[i] ? CNT_ZERO : CNT_MAX;
            end else begin
               cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
         end else begin
            cnt_d[i] = cnt_q[i];
         end
      end
   end

   // Sticky flags (a set event beats a same-cycle clear) and the one-cycle tc pulse.
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      for (int i = 0; i < N_CH; i++) begin
         if (ev_ovf_s[i]) begin
            ovf_d[i] = 1'b1;
         end else if (bus.flag_clr[i]) begin
            ovf_d[i] = 1'b0;
         end else begin
            ovf_d[i] = ovf_q[i];
         end
         if (ev_unf_s[i]) begin
            unf_d[i] = 1'b1;
         end else if (bus.flag_clr[i]) begin
            unf_d[i] = 1'b0;
         end else begin
            unf_d[i] = unf_q[i];
         end
      end
      tc_d = ev_ovf_s | ev_unf_s;
   end

   // Snapshot captures the pre-update counters of every channel on the same edge.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         if (bus.snap) begin
            shadow_d[i] = cnt_q[i];
         end else begin
            shadow_d[i] = shadow_q[i];
         end
      end
      if (bus.snap) begin
         snap_cnt_d = snap_cnt_q + 16'd1;
      end else begin
         snap_cnt_d = snap_cnt_q;
      end
   end

   // Readout mux over the current shadows; out-of-range channel or word reads as zero.
   always_comb begin
      rd_data_d = 16'h0000;
      for (int c = 0; c < N_CH; c++) begin
         for (int w = 0; w < NW; w++) begin
            if ((bus.rd_sel == 4'(c)) && (bus.rd_word == 2'(w))) begin
               rd_data_d = shadow_q[c][16*w +: 16];
            end else begin
               rd_data_d = rd_data_d;
            end
         end
      end
   end

   // State registers with synchronous reset overriding every other input.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i]    <= CNT_ZERO;
            shadow_q[i] <= CNT_ZERO;
         end
         ovf_q      <= {N_CH{1'b0}};
         unf_q      <= {N_CH{1'b0}};
         tc_q       <= {N_CH{1'b0}};
         rd_data_q  <= 16'h0000;
         snap_cnt_q <= 16'h0000;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i]    <= cnt_d[i];
            shadow_q[i] <= shadow_d[i];
         end
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         tc_q       <= tc_d;
         rd_data_q  <= rd_data_d;
         snap_cnt_q <= snap_cnt_d;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.snap_cnt = snap_cnt_q;
   assign bus.ovf_flag = ovf_q;
   assign bus.unf_flag = unf_q;
   assign bus.tc_pulse = tc_q;
endmodule

// File: tb/tb_trig_counter_bank.sv
// Directed self-checking bench for trig_counter_bank (N_CH=4, CNT_W=32).
// Readout expectations go through a scoreboard queue; status outputs are
// checked directly against bench-computed constants.
module tb_trig_counter_bank;
   logic sys_clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   exp_snap = 0;

   logic [15:0] sb_exp [$];
   string       sb_tag [$];

   trig_counter_bank_if #(.N_CH(4), .CNT_W(32)) bus ();

   trig_counter_bank #(.N_CH(4), .CNT_W(32)) dut (
      .sys_clk (sys_clk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_trigs();
      bus.trig_reset = 4'b0000;
      bus.trig_load  = 4'b0000;
      bus.trig_up    = 4'b0000;
      bus.trig_down  = 4'b0000;
      bus.flag_clr   = 4'b0000;
      bus.snap       = 1'b0;
   endtask

   // Drive a read select, queue its expectation, and compare when rd_data updates.
   task automatic rd(input string tag, input logic [3:0] sel, input logic [1:0] word,
                     input logic [15:0] exp);
      logic [15:0] e;
      string       t;
      bus.rd_sel  = sel;
      bus.rd_word = word;
      sb_exp.push_back(exp);
      sb_tag.push_back(tag);
      tick();
      e = sb_exp.pop_front();
      t = sb_tag.pop_front();
      chk(t, {48'd0, bus.rd_data}, {48'd0, e});
   endtask

   task automatic do_snap();
      bus.snap = 1'b1;
      tick();
      bus.snap = 1'b0;
      exp_snap++;
   endtask

   task automatic load(input int ch, input logic [31:0] v);
      bus.load_value   = v;
      bus.trig_load[ch] = 1'b1;
      tick();
      bus.trig_load[ch] = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clr_trigs();
      bus.load_value = 32'h0;
      bus.sat_mode   = 4'b0000;
      bus.rd_sel     = 4'd0;
      bus.rd_word    = 2'd0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_rd_data", {48'd0, bus.rd_data}, 64'd0);
      chk("rst_snap_cnt", {48'd0, bus.snap_cnt}, 64'd0);
      chk("rst_ovf", {60'd0, bus.ovf_flag}, 64'd0);
      chk("rst_unf", {60'd0, bus.unf_flag}, 64'd0);
      chk("rst_tc", {60'd0, bus.tc_pulse}, 64'd0);

      // Five increments on ch0, snapshot, read both words.
      bus.trig_up = 4'b0001;
      repeat (5) tick();
      bus.trig_up = 4'b0000;
      do_snap();
      rd("ch0_w0", 4'd0, 2'd0, 16'h0005);
      rd("ch0_w1", 4'd0, 2'd1, 16'h0000);
      chk("snap_cnt_1", {48'd0, bus.snap_cnt}, 64'(exp_snap));

      // ch1 wrap at max.
      load(1, 32'hFFFF_FFFF);
      bus.trig_up = 4'b0010;
      tick();
      bus.trig_up = 4'b0000;
      chk("ch1_wrap_tc", {63'd0, bus.tc_pulse[1]}, 64'd1);
      chk("ch1_wrap_ovf", {63'd0, bus.ovf_flag[1]}, 64'd1);
      tick();
      chk("ch1_tc_one_cycle", {63'd0, bus.tc_pulse[1]}, 64'd0);
      do_snap();
      rd("ch1_wrap_w0", 4'd1, 2'd0, 16'h0000);
      rd("ch1_wrap_w1", 4'd1, 2'd1, 16'h0000);

      // ch1 saturate at max (flag cleared first so the set is observable).
      bus.sat_mode = 4'b0010;
      bus.flag_clr = 4'b0010;
      load(1, 32'hFFFF_FFFF);
      bus.flag_clr = 4'b0000;
      chk("ch1_ovf_cleared", {63'd0, bus.ovf_flag[1]}, 64'd0);
      bus.trig_up = 4'b0010;
      tick();
      bus.trig_up = 4'b0000;
      chk("ch1_sat_ovf", {63'd0, bus.ovf_flag[1]}, 64'd1);
      chk("ch1_sat_tc", {63'd0, bus.tc_pulse[1]}, 64'd1);
      do_snap();
      rd("ch1_sat_w0", 4'd1, 2'd0, 16'hFFFF);
      rd("ch1_sat_w1", 4'd1, 2'd1, 16'hFFFF);

      // ch2 saturating underflow and set-beats-clear.
      bus.sat_mode = 4'b0100;
      bus.trig_down = 4'b0100;
      tick();
      chk("ch2_unf", {63'd0, bus.unf_flag[2]}, 64'd1);
      chk("ch2_unf_tc", {60'd0, bus.tc_pulse}, 64'h4);
      bus.flag_clr = 4'b0100;
      tick();
      bus.trig_down = 4'b0000;
      chk("ch2_set_wins", {63'd0, bus.unf_flag[2]}, 64'd1);
      tick();
      bus.flag_clr = 4'b0000;
      chk("ch2_clr_alone", {63'd0, bus.unf_flag[2]}, 64'd0);
      do_snap();
      rd("ch2_sat_w0", 4'd2, 2'd0, 16'h0000);

      // ch3 priority: reset beats load and up; up+down holds with no tc.
      load(3, 32'd7);
      bus.load_value = 32'h1234_5678;
      bus.trig_reset = 4'b1000;
      bus.trig_load  = 4'b1000;
      bus.trig_up    = 4'b1000;
      tick();
      clr_trigs();
      do_snap();
      rd("ch3_prio", 4'd3, 2'd0, 16'h0000);
      load(3, 32'd7);
      bus.trig_up   = 4'b1000;
      bus.trig_down = 4'b1000;
      tick();
      clr_trigs();
      chk("ch3_hold_no_tc", {60'd0, bus.tc_pulse}, 64'd0);
      do_snap();
      rd("ch3_hold", 4'd3, 2'd0, 16'h0007);

      // Snapshot takes the pre-update value when coincident with a trigger.
      load(0, 32'h0001_FFFF);
      bus.trig_up = 4'b0001;
      do_snap();
      bus.trig_up = 4'b0000;
      rd("snap_pre_w0", 4'd0, 2'd0, 16'hFFFF);
      rd("snap_pre_w1", 4'd0, 2'd1, 16'h0001);
      bus.trig_up = 4'b0001;
      repeat (3) tick();
      bus.trig_up = 4'b0000;
      rd("shadow_stable", 4'd0, 2'd0, 16'hFFFF);
      bus.snap = 1'b1;
      exp_snap++;
      rd("snap_rd_old", 4'd0, 2'd0, 16'hFFFF);
      bus.snap = 1'b0;
      rd("snap_rd_new", 4'd0, 2'd0, 16'h0003);
      rd("rd_sel_oob", 4'd5, 2'd0, 16'h0000);
      rd("rd_word_oob", 4'd0, 2'd2, 16'h0000);
      chk("snap_cnt_mid", {48'd0, bus.snap_cnt}, 64'(exp_snap));

      // Mid-operation reset with flags set and triggers/snap active.
      bus.trig_down = 4'b0100;
      tick();
      bus.trig_down = 4'b0000;
      reset = 1'b1;
      bus.trig_up  = 4'b0011;
      bus.snap     = 1'b1;
      bus.rd_sel   = 4'd0;
      bus.rd_word  = 2'd0;
      tick();
      reset = 1'b0;
      clr_trigs();
      exp_snap = 0;
      chk("mrst_rd_data", {48'd0, bus.rd_data}, 64'd0);
      chk("mrst_snap_cnt", {48'd0, bus.snap_cnt}, 64'd0);
      chk("mrst_ovf", {60'd0, bus.ovf_flag}, 64'd0);
      chk("mrst_unf", {60'd0, bus.unf_flag}, 64'd0);
      chk("mrst_tc", {60'd0, bus.tc_pulse}, 64'd0);

      // snap_cnt wraps 0xFFFF -> 0.
      bus.snap = 1'b1;
      repeat (65535) tick();
      bus.snap = 1'b0;
      chk("snap_cnt_max", {48'd0, bus.snap_cnt}, 64'h FFFF);
      bus.snap = 1'b1;
      tick();
      bus.snap = 1'b0;
      chk("snap_cnt_wrap", {48'd0, bus.snap_cnt}, 64'd0);
      rd("post_rst_ch0", 4'd0, 2'd0, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/trig_counter_bank.md
Name: trig_counter_bank

Overview:
Parametrised bank of N_CH independent up/down event counters. Each channel is driven by host trigger pulses (reset, up, down, load). Each channel selects wrap or saturate mode and raises sticky overflow/underflow flags. A snapshot strobe captures all channels in the same cycle into shadow registers, which are read out 16 bits at a time through a registered mux, giving coherent multi-word reads over 16-bit wire-out endpoints.

Parameters:
N_CH, 4, number of counter channels (1..16)
CNT_W, 32, counter width in bits; multiple of 16, range 16..64

Ports:
sys_clk  in  1  clock
reset  in  1  synchronous, active-high reset
trig_reset  in  N_CH  per-channel one-cycle pulse: clear counter to 0
trig_load  in  N_CH  per-channel pulse: load load_value
trig_up  in  N_CH  per-channel pulse: increment by 1
trig_down  in  N_CH  per-channel pulse: decrement by 1
load_value  in  CNT_W  shared load data
sat_mode  in  N_CH  per channel: 1 = saturate, 0 = wrap
flag_clr  in  N_CH  per-channel pulse: clear ovf/unf flags
snap  in  1  pulse: capture all counters into shadow registers
rd_sel  in  4  channel select for readout
rd_word  in  2  16-bit word select within the shadow (0 = LSW)
rd_data  out  16  registered readout word
snap_cnt  out  16  number of snapshots taken, wraps
ovf_flag  out  N_CH  sticky overflow (up at max)
unf_flag  out  N_CH  sticky underflow (down at 0)
tc_pulse  out  N_CH  one-cycle pulse on any overflow/underflow event

Behaviour:
- Reset: all counters, shadows, rd_data, snap_cnt, ovf_flag, unf_flag and tc_pulse are 0.
- Per-channel priority each cycle: trig_reset > trig_load > (trig_up & trig_down → hold) > trig_up > trig_down > hold.
- Up at max (2^CNT_W-1):
  - wrap mode → 0;
  - sat mode → holds max;
  - both cases set ovf_flag and pulse tc_pulse for one cycle (cycle after the trigger).
- Down at 0:
  - wrap mode → max;
  - sat mode → holds 0;
  - both cases set unf_flag and pulse tc_pulse.
- No event on reset, load, or the simultaneous up+down hold.
- Counter updates appear on the output/shadow path 1 cycle after the trigger.
- Flags: flag_clr clears both flags of that channel. If a set event and flag_clr occur in the same cycle, the set wins (flag = 1).
- Snapshot: on snap, every shadow[i] takes the counter value present at that same sys_clk edge, i.e. pre-update, excluding any trigger sampled in that cycle. snap_cnt increments by 1 and wraps 0xFFFF→0.
- Shadows only change on snap; counting between snapshots does not alter readout.
- Readout: rd_data = shadow[rd_sel][16*rd_word +: 16], registered, 1-cycle latency.
  - rd_sel ≥ N_CH → 0.
  - rd_word ≥ CNT_W/16 → 0.
  - snap and read in the same cycle → rd_data shows the old shadow; the new shadow is visible on the next cycle.
- Reset asserted mid-operation overrides all triggers, snap and clears in that cycle.
- Triggers are assumed to be synchronous to sys_clk (pulses already in sys_clk domain).

Test Plan:
- Reset, then 5 trig_up pulses on ch0, snap, rd_sel=0 rd_word=0 → rd_data=0x0005 one cycle later; rd_word=1 → 0x0000; snap_cnt=1.
- ch1 sat_mode=0, load 0xFFFFFFFF, trig_up → counter 0x00000000, ovf_flag[1]=1, tc_pulse[1] high exactly 1 cycle. Repeat with sat_mode=1 → counter stays 0xFFFFFFFF, ovf_flag set.
- ch2 at 0, trig_down with sat_mode=1 → stays 0, unf_flag[2]=1. Then flag_clr[2] coincident with another trig_down → unf_flag[2] remains 1. Next flag_clr alone → 0.
- Same cycle trig_reset+trig_load+trig_up on ch3 → 0. trig_up+trig_down together from 7 → stays 7, no tc_pulse.
- Counter at 0x0001FFFF, snap coincident with trig_up → shadow reads 0xFFFF / 0x0001. Continued counting without snap leaves rd_data unchanged. rd_sel=5 (N_CH=4) → 0x0000.
- Assert reset while counters are nonzero and flags set → all outputs 0 the next cycle. snap_cnt wraps from 0xFFFF to 0 after the 65536th snap.
